// File: rtl/fft_pkg.sv
// Shared complex type, twiddle tables and saturation helpers for the pipelined radix-2 FFT.
`define FFT_CPLX_T(W) struct packed { logic signed [(W)-1:0] re; logic signed [(W)-1:0] im; }

package fft_pkg;

  localparam real TWO_PI = 6.283185307179586;

  function automatic int bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int b = 0; b < nbits; b++) begin
      if (((idx >> b) & 1) != 0) r = r | (1 << (nbits - 1 - b));
    end
    return r;
  endfunction

  // Quantise a real in [-1,1] to Q1.(tw-1); +1.0 clamps to the largest positive code.
  function automatic int tw_quant(input real v, input int tw);
    real s;
    int  q;
    int  hi;
    hi = (1 << (tw - 1)) - 1;
    s  = v * $itor(1 << (tw - 1));
    q  = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    if (q > hi) q = hi;
    if (q < -hi - 1) q = -hi - 1;
    return q;
  endfunction

  function automatic int tw_re(input int k, input int n, input int tw);
    return tw_quant($cos(TWO_PI * $itor(k) / $itor(n)), tw);
  endfunction

  function automatic int tw_im(input int k, input int n, input int tw);
    return tw_quant(-$sin(TWO_PI * $itor(k) / $itor(n)), tw);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fft_r2_bfly.sv
// Combinational DIF butterfly: a' = a+b, b' = (a-b)*W_N^TW_IDX, optional >>>1, saturating.
module fft_r2_bfly
  import fft_pkg::*;
#(
  parameter int DW       = 16,
  parameter int TW       = 16,
  parameter bit SCALE_EN = 1'b1,
  parameter int TW_IDX   = 0,
  parameter int N        = 8
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  output logic signed [DW-1:0] y0_re,
  output logic signed [DW-1:0] y0_im,
  output logic signed [DW-1:0] y1_re,
  output logic signed [DW-1:0] y1_im,
  output logic                 ovf
);

  localparam int SW = DW + 1;
  localparam int PW = SW + TW + 2;

  logic signed [SW-1:0] s_re, s_im, d_re, d_im;
  logic                 sum_ovf, dif_ovf;

  always_comb begin
    s_re = SW'(a_re) + SW'(b_re);
    s_im = SW'(a_im) + SW'(b_im);
    d_re = SW'(a_re) - SW'(b_re);
    d_im = SW'(a_im) - SW'(b_im);
    if (SCALE_EN) begin
      s_re = s_re >>> 1;
      s_im = s_im >>> 1;
      d_re = d_re >>> 1;
      d_im = d_im >>> 1;
    end
    y0_re   = DW'(sat(64'(s_re), DW));
    y0_im   = DW'(sat(64'(s_im), DW));
    sum_ovf = (SW'(y0_re) != s_re) | (SW'(y0_im) != s_im);
  end

  // W = 1 at k = 0, so that path skips the multiplier and stays exact.
  generate
    if (TW_IDX == 0) begin : g_bypass
      always_comb begin
        y1_re   = DW'(sat(64'(d_re), DW));
        y1_im   = DW'(sat(64'(d_im), DW));
        dif_ovf = (SW'(y1_re) != d_re) | (SW'(y1_im) != d_im);
      end
    end else begin : g_mult
      localparam logic signed [PW-1:0] WR  = PW'(tw_re(TW_IDX, N, TW));
      localparam logic signed [PW-1:0] WI  = PW'(tw_im(TW_IDX, N, TW));
      localparam logic signed [PW-1:0] RND = PW'(64'sd1 <<< (TW - 2));
      logic signed [PW-1:0] dre_w, dim_w, m_re, m_im;
      always_comb begin
        dre_w   = PW'(d_re);
        dim_w   = PW'(d_im);
        m_re    = (dre_w * WR - dim_w * WI + RND) >>> (TW - 1);
        m_im    = (dre_w * WI + dim_w * WR + RND) >>> (TW - 1);
        y1_re   = DW'(sat(64'(m_re), DW));
        y1_im   = DW'(sat(64'(m_im), DW));
        dif_ovf = (PW'(y1_re) != m_re) | (PW'(y1_im) != m_im);
      end
    end
  endgenerate

  assign ovf = sum_ovf | dif_ovf;

endmodule

// File: rtl/fft_r2_pipe.sv
// Stage-pipelined parallel radix-2 DIF FFT: one N-point vector per cycle, valid/ready, sticky overflow.
module fft_r2_pipe
  import fft_pkg::*;
#(
  parameter int                   N             = 8,
  parameter int                   DW            = 16,
  parameter int                   TW            = 16,
  parameter logic [$clog2(N)-1:0] SCALE         = '1,
  parameter bit                   NATURAL_ORDER = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_re,
  input  logic [N*DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*DW-1:0] out_re,
  output logic [N*DW-1:0] out_im,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);

  localparam int NS = $clog2(N);

  typedef `FFT_CPLX_T(DW) cplx_t;

  cplx_t           src [NS][N];
  cplx_t           nxt [NS][N];
  cplx_t           st  [NS][N];
  logic [NS-1:0]   st_v;
  logic [N/2-1:0]  bov [NS];
  logic            adv;
  logic            any_ovf;

  assign out_valid = st_v[NS-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  generate
    for (genvar s = 0; s < NS; s++) begin : g_stage
      localparam int L = N >> s;
      localparam int H = L / 2;

      for (genvar n = 0; n < N; n++) begin : g_src
        if (s == 0) begin : g_in
          assign src[s][n] = {in_re[n*DW +: DW], in_im[n*DW +: DW]};
        end else begin : g_prev
          assign src[s][n] = st[s-1][n];
        end
      end

      // Butterfly b pairs (I, I+H) inside its L-block; twiddle index is p<<s.
      for (genvar b = 0; b < N/2; b++) begin : g_bf
        localparam int P = b % H;
        localparam int I = (b / H) * L + P;
        localparam int J = I + H;
        logic signed [DW-1:0] y0r, y0i, y1r, y1i;
        fft_r2_bfly #(
          .DW      (DW),
          .TW      (TW),
          .SCALE_EN(SCALE[s]),
          .TW_IDX  (P << s),
          .N       (N)
        ) u_bfly (
          .a_re (src[s][I].re),
          .a_im (src[s][I].im),
          .b_re (src[s][J].re),
          .b_im (src[s][J].im),
          .y0_re(y0r),
          .y0_im(y0i),
          .y1_re(y1r),
          .y1_im(y1i),
          .ovf  (bov[s][b])
        );
        assign nxt[s][I] = {y0r, y0i};
        assign nxt[s][J] = {y1r, y1i};
      end
    end
  endgenerate

  // Only butterflies fed by a valid vector may raise the sticky flag.
  always_comb begin
    any_ovf = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (s == 0) any_ovf = any_ovf | (in_valid & (|bov[s]));
      else        any_ovf = any_ovf | (st_v[s-1] & (|bov[s]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_v       <= '0;
      ovf_sticky <= 1'b0;
      for (int s = 0; s < NS; s++)
        for (int n = 0; n < N; n++)
          st[s][n] <= '0;
    end else begin
      if (adv) begin
        st_v <= {st_v[NS-2:0], in_valid};
        for (int s = 0; s < NS; s++)
          for (int n = 0; n < N; n++)
            st[s][n] <= nxt[s][n];
      end
      if (adv && any_ovf)
        ovf_sticky <= 1'b1;
      else if (ovf_clr)
        ovf_sticky <= 1'b0;
    end
  end

  // DIF leaves bin k at position bitrev(k) of the last stage.
  generate
    for (genvar k = 0; k < N; k++) begin : g_out
      localparam int POS = NATURAL_ORDER ? bitrev(k, NS) : k;
      assign out_re[k*DW +: DW] = st[NS-1][POS].re;
      assign out_im[k*DW +: DW] = st[NS-1][POS].im;
    end
  endgenerate

endmodule

// File: tb/tb_fft_r2_pipe.sv
// Directed bench for fft_r2_pipe: scaled natural-order, unscaled, and bit-reversed instances in lockstep.
module tb_fft_r2_pipe;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, out_ready, ovf_clr;
  logic [N*DW-1:0] in_re, in_im;

  logic            in_ready, out_valid, ovf_sticky;
  logic [N*DW-1:0] out_re, out_im;
  logic            in_ready_ns, out_valid_ns, ovf_sticky_ns;
  logic [N*DW-1:0] out_re_ns, out_im_ns;
  logic            in_ready_br, out_valid_br, ovf_sticky_br;
  logic [N*DW-1:0] out_re_br, out_im_br;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_r2_pipe #(.N(N), .DW(DW), .TW(TW), .SCALE(3'b111), .NATURAL_ORDER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  fft_r2_pipe #(.N(N), .DW(DW), .TW(TW), .SCALE(3'b000), .NATURAL_ORDER(1'b1)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ns),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_ns), .out_ready(out_ready),
    .out_re(out_re_ns), .out_im(out_im_ns), .ovf_sticky(ovf_sticky_ns), .ovf_clr(ovf_clr)
  );

  fft_r2_pipe #(.N(N), .DW(DW), .TW(TW), .SCALE(3'b111), .NATURAL_ORDER(1'b0)) dut_br (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_br),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_br), .out_ready(out_ready),
    .out_re(out_re_br), .out_im(out_im_br), .ovf_sticky(ovf_sticky_br), .ovf_clr(ovf_clr)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp_v, input int tol);
    int d;
    n_checks++;
    d = obs - exp_v;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  function automatic int el(input logic [N*DW-1:0] v, input int k);
    return int'($signed(v[k*DW +: DW]));
  endfunction

  task automatic setVec(input int vr[N], input int vi[N]);
    for (int k = 0; k < N; k++) begin
      in_re[k*DW +: DW] = DW'(vr[k]);
      in_im[k*DW +: DW] = DW'(vi[k]);
    end
  endtask

  // Present one vector, return cycles from presentation to out_valid.
  task automatic applyStimulus(input int vr[N], input int vi[N], output int lat);
    setVec(vr, vi);
    in_valid = 1'b1;
    checkOutput("accept_rdy", in_ready, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int vr[N];
  int vi[N];
  int zero[N];
  int tone[N];
  int lat, got, first_c, last_c, nin, stale;
  bit acc, cons;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    zero      = '{0, 0, 0, 0, 0, 0, 0, 0};
    tone      = '{8000, 5657, 0, -5657, -8000, -5657, 0, 5657};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    setVec(zero, zero);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0, 0);
    checkOutput("rst_out_re0", el(out_re, 0), 0, 0);
    checkOutput("rst_ovf", ovf_sticky, 0, 0);
    checkOutput("rst_in_ready", in_ready, 1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] impulse");
    vr = zero; vr[0] = 1000;
    applyStimulus(vr, zero, lat);
    checkOutput("imp_latency", lat, 3, 0);
    checkOutput("imp_br_valid", out_valid_br, 1, 0);
    for (int k = 0; k < N; k++) begin
      checkOutput("imp_re", el(out_re, k), 125, 1);
      checkOutput("imp_im", el(out_im, k), 0, 1);
      checkOutput("imp_ns_re", el(out_re_ns, k), 1000, 0);
      checkOutput("imp_br_re", el(out_re_br, k), 125, 1);
      checkOutput("imp_br_im", el(out_im_br, k), 0, 1);
    end
    checkOutput("imp_ovf", ovf_sticky, 0, 0);

    $display("[TB] dc");
    vr = '{800, 800, 800, 800, 800, 800, 800, 800};
    applyStimulus(vr, zero, lat);
    checkOutput("dc_latency", lat, 3, 0);
    checkOutput("dc_bin0", el(out_re, 0), 800, 1);
    checkOutput("dc_ns_bin0", el(out_re_ns, 0), 6400, 0);
    for (int k = 1; k < N; k++) checkOutput("dc_re_other", el(out_re, k), 0, 1);
    for (int k = 0; k < N; k++) checkOutput("dc_im", el(out_im, k), 0, 1);

    $display("[TB] tone");
    applyStimulus(tone, zero, lat);
    for (int k = 0; k < N; k++) begin
      checkOutput("tone_re", el(out_re, k), (k == 1 || k == 7) ? 4000 : 0, 2);
      checkOutput("tone_im", el(out_im, k), 0, 2);
      checkOutput("tone_br_re", el(out_re_br, k), (k == 4 || k == 7) ? 4000 : 0, 2);
    end
    checkOutput("tone_ns_bin1", el(out_re_ns, 1), 32000, 8);
    checkOutput("tone_ns_ovf", ovf_sticky_ns, 0, 0);
    @(posedge clk); #1;

    $display("[TB] streaming back-to-back");
    got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        vr = zero; vr[0] = 800 * (c + 1);
        setVec(vr, zero);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        checkOutput("strm_order", el(out_re, 0), 100 * (got + 1), 0);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
    end
    checkOutput("strm_count", got, 5, 0);
    checkOutput("strm_span", last_c - first_c, 4, 0);
    checkOutput("strm_first", first_c, 2, 0);

    $display("[TB] streaming with output stall");
    got = 0; nin = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (nin < 5) begin
        vr = zero; vr[0] = 800 * (nin + 6);
        setVec(vr, zero);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 6) begin
        checkOutput("stall_in_ready", in_ready, 0, 0);
        checkOutput("stall_ns_ready", in_ready_ns, 0, 0);
        checkOutput("stall_out_valid", out_valid, 1, 0);
        checkOutput("stall_hold", el(out_re, 0), 100 * (got + 6), 0);
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        checkOutput("stall_order", el(out_re, 0), 100 * (got + 6), 0);
        got++;
      end
      @(posedge clk); #1;
      if (acc) nin++;
    end
    checkOutput("stall_count", got, 5, 0);
    checkOutput("stall_accepted", nin, 5, 0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] overflow");
    checkOutput("ovf_ns_pre", ovf_sticky_ns, 0, 0);
    vr = '{30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000};
    applyStimulus(vr, zero, lat);
    checkOutput("ovf_ns_bin0", el(out_re_ns, 0), 32767, 0);
    checkOutput("ovf_ns_im0", el(out_im_ns, 0), 0, 0);
    checkOutput("ovf_ns_flag", ovf_sticky_ns, 1, 0);
    checkOutput("ovf_scaled_bin0", el(out_re, 0), 30000, 0);
    checkOutput("ovf_scaled_flag", ovf_sticky, 0, 0);
    setVec(zero, zero);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ovf_ns_hold", ovf_sticky_ns, 1, 0);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checkOutput("ovf_ns_cleared", ovf_sticky_ns, 0, 0);
    @(posedge clk); #1;
    checkOutput("ovf_ns_stays_clear", ovf_sticky_ns, 0, 0);

    $display("[TB] reset with vectors in flight");
    for (int c = 0; c < 2; c++) begin
      vr = zero; vr[0] = 2000 + 1000 * c;
      setVec(vr, zero);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_valid", out_valid, 0, 0);
    checkOutput("midrst_br_valid", out_valid_br, 0, 0);
    checkOutput("midrst_re0", el(out_re, 0), 0, 0);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid_ns || out_valid_br) stale++;
    end
    checkOutput("midrst_stale", stale, 0, 0);

    $display("[TB] impulse after reset, bit-reversed instance");
    vr = zero; vr[0] = 1000;
    applyStimulus(vr, zero, lat);
    checkOutput("imp2_latency", lat, 3, 0);
    for (int k = 0; k < N; k++) checkOutput("imp2_br_re", el(out_re_br, k), 125, 1);
    checkOutput("imp2_br_ovf", ovf_sticky_br, 0, 0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
